// File: rtl/tidc_grant_ack_tracker.sv
// Issues TileLink Grants with a sink ID from the sink ID manager and retires them on GrantAck.
// States: IDLE wait for request | AREQ request ID | AWAIT wait for grant | SEND drive D channel
module tidc_grant_ack_tracker #(
    parameter int SINK_W = 3,
    parameter int SRC_W  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SRC_W-1:0]  req_source,
    input  logic [1:0]        req_param,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              alloc_req,
    input  logic              alloc_gnt,
    input  logic [SINK_W-1:0] alloc_sink_id,
    output logic              dealloc_req,
    output logic [SINK_W-1:0] dealloc_sink_id,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [SRC_W-1:0]  d_source,
    output logic [SINK_W-1:0] d_sink,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic [SINK_W-1:0] e_sink,
    output logic              done_valid,
    output logic [ADDR_W-1:0] done_addr,
    output logic [SRC_W-1:0]  done_source,
    output logic              err_bad_sink,
    output logic [SINK_W:0]   outstanding
);
    localparam int NENT = 1 << SINK_W;
    localparam logic [SINK_W:0] NENT_C = {1'b1, {SINK_W{1'b0}}};
    localparam logic [SINK_W:0] ONE    = {{SINK_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, AREQ, AWAIT, SEND} state_t;
    state_t state;

    logic [SRC_W-1:0]  lat_source;
    logic [1:0]        lat_param;
    logic [ADDR_W-1:0] lat_addr;
    logic [NENT-1:0]   tbl_valid;
    logic [SRC_W-1:0]  tbl_source [NENT];
    logic [ADDR_W-1:0] tbl_addr   [NENT];
    logic              d_fire;
    logic              e_hit;
    logic [SINK_W:0]   out_nxt;

    assign d_fire  = d_valid && d_ready;
    assign e_hit   = e_valid && tbl_valid[e_sink];
    assign e_ready = 1'b1;

    always_comb begin
        out_nxt = outstanding;
        if (d_fire && !e_hit)
            out_nxt = outstanding + ONE;
        else if (!d_fire && e_hit)
            out_nxt = outstanding - ONE;
    end

    // alloc_req is decided on the edge entering AREQ from next-cycle occupancy, so it is a one-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            req_ready       <= 1'b0;
            alloc_req       <= 1'b0;
            lat_source      <= '0;
            lat_param       <= '0;
            lat_addr        <= '0;
            d_valid         <= 1'b0;
            d_opcode        <= '0;
            d_param         <= '0;
            d_source        <= '0;
            d_sink          <= '0;
            outstanding     <= '0;
            dealloc_req     <= 1'b0;
            dealloc_sink_id <= '0;
            done_valid      <= 1'b0;
            done_addr       <= '0;
            done_source     <= '0;
            err_bad_sink    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_source <= req_source;
                        lat_param  <= req_param;
                        lat_addr   <= req_addr;
                        req_ready  <= 1'b0;
                        alloc_req  <= (out_nxt < NENT_C);
                        state      <= AREQ;
                    end else begin
                        req_ready  <= 1'b1;
                    end
                end
                AREQ: begin
                    if (alloc_req) begin
                        alloc_req <= 1'b0;
                        state     <= AWAIT;
                    end else begin
                        alloc_req <= (out_nxt < NENT_C);
                    end
                end
                AWAIT: begin
                    if (alloc_gnt) begin
                        d_valid  <= 1'b1;
                        d_opcode <= 3'd4;
                        d_param  <= lat_param;
                        d_source <= lat_source;
                        d_sink   <= alloc_sink_id;
                        state    <= SEND;
                    end else begin
                        alloc_req <= (out_nxt < NENT_C);
                        state     <= AREQ;
                    end
                end
                SEND: begin
                    if (d_ready) begin
                        d_valid   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            outstanding  <= out_nxt;
            dealloc_req  <= e_hit;
            done_valid   <= e_hit;
            err_bad_sink <= e_valid && !tbl_valid[e_sink];
            if (e_hit) begin
                dealloc_sink_id <= e_sink;
                done_addr       <= tbl_addr[e_sink];
                done_source     <= tbl_source[e_sink];
            end
        end
    end

    // Valid bit is sampled before the write, so an ack to the sink being granted this cycle misses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_valid <= '0;
        end else begin
            if (d_fire)
                tbl_valid[d_sink] <= 1'b1;
            if (e_hit)
                tbl_valid[e_sink] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (d_fire) begin
            tbl_source[d_sink] <= lat_source;
            tbl_addr[d_sink]   <= lat_addr;
        end
    end
endmodule

// File: tb/tb_tidc_grant_ack_tracker.sv
// Directed bench for tidc_grant_ack_tracker with a sink ID manager model and D/E scoreboards.
module tb_tidc_grant_ack_tracker;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_source;
    logic [1:0]  req_param;
    logic [31:0] req_addr;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [2:0]  alloc_sink_id;
    logic        dealloc_req;
    logic [2:0]  dealloc_sink_id;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_source;
    logic [2:0]  d_sink;
    logic        e_valid;
    logic        e_ready;
    logic [2:0]  e_sink;
    logic        done_valid;
    logic [31:0] done_addr;
    logic [3:0]  done_source;
    logic        err_bad_sink;
    logic [3:0]  outstanding;

    tidc_grant_ack_tracker dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_source(req_source),
        .req_param(req_param), .req_addr(req_addr),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_sink_id(alloc_sink_id),
        .dealloc_req(dealloc_req), .dealloc_sink_id(dealloc_sink_id),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_source(d_source), .d_sink(d_sink),
        .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink),
        .done_valid(done_valid), .done_addr(done_addr), .done_source(done_source),
        .err_bad_sink(err_bad_sink), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] param; logic [3:0] src; logic [31:0] addr; } d_exp_t;
    typedef struct { int due; bit hit; logic [2:0] sink; logic [31:0] addr; logic [3:0] src; } e_exp_t;

    d_exp_t      exp_d[$];
    e_exp_t      exp_e[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          withhold = 0;
    bit [7:0]    free_ids;
    bit [7:0]    mdl_valid;
    logic [3:0]  mdl_src  [8];
    logic [31:0] mdl_addr [8];
    logic [2:0]  gnt_id;
    bit          prev_alloc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        d_exp_t de;
        e_exp_t ee;
        if (alloc_req) chk("alloc_req_back_to_back", prev_alloc, 0);
        prev_alloc = alloc_req;
        if (d_valid && d_ready) begin
            chk("d_fire_expected", exp_d.size() != 0, 1);
            if (exp_d.size() != 0) begin
                de = exp_d.pop_front();
                chk("d_opcode", d_opcode, 4);
                chk("d_param", d_param, de.param);
                chk("d_source", d_source, de.src);
                chk("d_sink", d_sink, gnt_id);
                mdl_valid[gnt_id] = 1'b1;
                mdl_src[gnt_id]   = de.src;
                mdl_addr[gnt_id]  = de.addr;
            end
        end
        if (exp_e.size() != 0 && exp_e[0].due == cyc) begin
            ee = exp_e.pop_front();
            chk("done_valid", done_valid, ee.hit);
            chk("dealloc_req", dealloc_req, ee.hit);
            chk("err_bad_sink", err_bad_sink, !ee.hit);
            if (ee.hit) begin
                chk("dealloc_sink_id", dealloc_sink_id, ee.sink);
                chk("done_addr", done_addr, ee.addr);
                chk("done_source", done_source, ee.src);
            end
        end else begin
            chk("spurious_e_result", {done_valid, dealloc_req, err_bad_sink}, 0);
        end
        if (dealloc_req) free_ids[dealloc_sink_id] = 1'b1;
    endtask

    // Manager: answers the cycle after alloc_req with the lowest free ID unless told to withhold
    task automatic manager();
        alloc_gnt     = 1'b0;
        alloc_sink_id = '0;
        if (prev_alloc) begin
            if (withhold > 0) begin
                withhold--;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (free_ids[i] && !alloc_gnt) begin
                        alloc_gnt     = 1'b1;
                        alloc_sink_id = 3'(i);
                        gnt_id        = 3'(i);
                        free_ids[i]   = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        manager();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_source = '0; req_param = '0; req_addr = '0;
        alloc_gnt = 1'b0; alloc_sink_id = '0; d_ready = 1'b1; e_valid = 1'b0; e_sink = '0;
        repeat (2) @(posedge clk);
        exp_d.delete();
        exp_e.delete();
        free_ids = '1;
        mdl_valid = '0;
        prev_alloc = 1'b0;
        withhold = 0;
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk(tag, {req_ready, alloc_req, dealloc_req, d_valid, done_valid, err_bad_sink, e_ready}, 7'b0000001);
        chk({tag, "_outstanding"}, outstanding, 0);
        chk({tag, "_d_fields"}, {d_opcode, d_param, d_source, d_sink}, 0);
    endtask

    task automatic issue(input logic [3:0] s, input logic [1:0] p, input logic [31:0] a);
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        chk("issue_ready_timeout", req_ready, 1);
        req_valid = 1'b1; req_source = s; req_param = p; req_addr = a;
        exp_d.push_back('{p, s, a});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        chk("wait_idle_timeout", req_ready, 1);
    endtask

    task automatic wait_dvalid();
        int n = 0;
        while (!d_valid && n < 50) begin tick(); n++; end
        chk("wait_dvalid_timeout", d_valid, 1);
    endtask

    task automatic ack(input logic [2:0] s);
        e_exp_t ee;
        ee.due  = cyc + 1;
        ee.hit  = mdl_valid[s];
        ee.sink = s;
        ee.addr = mdl_addr[s];
        ee.src  = mdl_src[s];
        if (ee.hit) mdl_valid[s] = 1'b0;
        exp_e.push_back(ee);
        e_valid = 1'b1; e_sink = s;
        tick();
        e_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit [5:0] pat = 6'b010101;
        rst = 1'b1;
        req_valid = 1'b0; req_source = '0; req_param = '0; req_addr = '0;
        alloc_gnt = 1'b0; alloc_sink_id = '0; d_ready = 1'b1; e_valid = 1'b0; e_sink = '0;
        @(posedge clk); #1;
        chk_rst_outputs("reset_state");
        do_reset();
        tick();
        chk("idle_req_ready", req_ready, 1);

        // single grant with exact latency
        issue(4'd3, 2'd1, 32'h1000);
        chk("t1_alloc_req", alloc_req, 1);
        tick();
        chk("t2_d_valid", d_valid, 0);
        chk("t2_alloc_req", alloc_req, 0);
        tick();
        chk("t3_d_valid", d_valid, 1);
        chk("t3_d_fields", {d_opcode, d_param, d_source, d_sink}, {3'd4, 2'd1, 4'd3, 3'd0});
        tick();
        chk("t4_req_ready", req_ready, 1);
        chk("t4_outstanding", outstanding, 1);
        ack(3'd0);
        chk("single_out_after_ack", outstanding, 0);
        tick();

        // fill all eight entries, ninth request stalls until an ack frees sink 5
        do_reset();
        tick();
        for (int i = 0; i < 8; i++) begin
            issue(4'(i), 2'(i % 3), 32'h2000 + 32'(i) * 32'h40);
            wait_idle();
        end
        chk("fill_outstanding", outstanding, 8);
        issue(4'd9, 2'd2, 32'h3000);
        repeat (5) begin
            chk("fill_stall_alloc_req", alloc_req, 0);
            chk("fill_stall_d_valid", d_valid, 0);
            tick();
        end
        ack(3'd5);
        chk("fill_out_after_ack", outstanding, 7);
        chk("fill_alloc_resumes", alloc_req, 1);
        wait_dvalid();
        chk("fill_d_sink", d_sink, 5);
        wait_idle();
        chk("fill_outstanding_again", outstanding, 8);

        // manager withholds the grant twice
        do_reset();
        tick();
        withhold = 2;
        issue(4'd7, 2'd2, 32'h4000);
        for (int k = 0; k < 6; k++) begin
            chk("withhold_alloc_req", alloc_req, pat[k]);
            chk("withhold_d_valid_low", d_valid, 0);
            tick();
        end
        chk("withhold_d_valid_t7", d_valid, 1);
        wait_idle();

        // D backpressure for five cycles
        d_ready = 1'b0;
        issue(4'hA, 2'd0, 32'h5000);
        wait_dvalid();
        for (int k = 0; k < 5; k++) begin
            chk("bp_d_valid", d_valid, 1);
            chk("bp_d_fields", {d_opcode, d_param, d_source, d_sink}, {3'd4, 2'd0, 4'hA, 3'd1});
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        d_ready = 1'b1;
        tick();
        chk("bp_req_ready_after_fire", req_ready, 1);
        chk("bp_d_valid_after_fire", d_valid, 0);
        chk("bp_outstanding", outstanding, 2);

        // bad ack, then back-to-back good acks
        ack(3'd6);
        chk("bad_ack_outstanding", outstanding, 2);
        ack(3'd0);
        ack(3'd1);
        tick();
        chk("b2b_ack_outstanding", outstanding, 0);

        // same-cycle D fire to sink 2 and E ack of sink 1
        do_reset();
        tick();
        issue(4'd1, 2'd0, 32'h6000);
        wait_idle();
        issue(4'd2, 2'd1, 32'h6040);
        wait_idle();
        d_ready = 1'b0;
        issue(4'd3, 2'd2, 32'h6080);
        wait_dvalid();
        chk("same_d_sink", d_sink, 2);
        d_ready = 1'b1;
        ack(3'd1);
        chk("same_outstanding", outstanding, 2);
        chk("same_d_valid_low", d_valid, 0);
        ack(3'd1);
        ack(3'd2);
        tick();
        chk("same_out_after", outstanding, 1);

        // ack to the sink being written in the same cycle misses
        d_ready = 1'b0;
        issue(4'd4, 2'd0, 32'h7000);
        wait_dvalid();
        chk("race_d_sink", d_sink, 1);
        d_ready = 1'b1;
        ack(3'd1);
        chk("race_outstanding", outstanding, 2);
        ack(3'd1);
        tick();
        chk("race_out_after", outstanding, 1);

        // reset in the middle of SEND
        d_ready = 1'b0;
        issue(4'd5, 2'd1, 32'h8000);
        wait_dvalid();
        rst = 1'b1;
        #1;
        chk_rst_outputs("mid_send_reset");
        do_reset();
        tick();
        ack(3'd0);
        tick();
        chk("post_reset_outstanding", outstanding, 0);
        issue(4'd6, 2'd0, 32'h9000);
        wait_idle();
        chk("post_reset_grant", outstanding, 1);
        tick();

        chk("exp_d_drained", exp_d.size(), 0);
        chk("exp_e_drained", exp_e.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
